// File: rtl/apb_pkg.sv
// Shared types and helpers for the APB memory slave: FSM state encoding,
// byte-lane constants and an elaboration-time log2.
package apb_pkg;

    typedef enum logic [1:0] {
        IDLE,
        WAIT,
        RESP
    } state_t;

    localparam int BYTE_W     = 8;
    localparam int DEF_DATA_W = 32;
    localparam int DEF_STRB_W = DEF_DATA_W / BYTE_W;

    // Ceiling log2, used only on parameters.
    function automatic int clog2(input int value);
        int result;
        result = 0;
        for (int i = 0; i < 31; i++) begin
            if ((longint'(1) << i) < longint'(value)) begin
                result = i + 1;
            end
        end
        return result;
    endfunction

endpackage

// File: rtl/apb_bytewe_ram.sv
// Single-port synchronous RAM with per-byte write enables and a registered read.
// Contents are intentionally not reset so the array maps onto block RAM.
module apb_bytewe_ram
    import apb_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W,
    parameter int DEPTH  = 256,
    localparam int NB    = DATA_W / BYTE_W,
    localparam int AW    = (clog2(DEPTH) > 0) ? clog2(DEPTH) : 1
) (
    input  logic              clk,
    input  logic [NB-1:0]     we,
    input  logic              re,
    input  logic [AW-1:0]     addr,
    input  logic [DATA_W-1:0] wdata,
    output logic [DATA_W-1:0] rdata
);

    logic [DATA_W-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        for (int i = 0; i < NB; i++) begin
            if (we[i]) begin
                mem[addr][i*BYTE_W +: BYTE_W] <= wdata[i*BYTE_W +: BYTE_W];
            end
        end
        if (re) begin
            rdata <= mem[addr];
        end
    end

endmodule

// File: rtl/apb_mem_slave_p.sv
// APB4 word-addressed memory slave with byte strobes, programmable wait states,
// alignment/range error response and a registered pready/pslverr.
module apb_mem_slave_p
    import apb_pkg::*;
#(
    parameter int DATA_W      = DEF_DATA_W,
    parameter int ADDR_W      = 12,
    parameter int DEPTH       = 256,
    parameter int WAIT_CYCLES = 0
) (
    input  logic                   clk,
    input  logic                   resetn,
    input  logic                   psel,
    input  logic                   penable,
    input  logic                   pwrite,
    input  logic [ADDR_W-1:0]      paddr,
    input  logic [DATA_W-1:0]      pwdata,
    input  logic [DATA_W/8-1:0]    pstrb,
    output logic [DATA_W-1:0]      prdata,
    output logic                   pready,
    output logic                   pslverr
);

    localparam int STRB_W   = DATA_W / BYTE_W;
    localparam int ADDR_LSB = clog2(STRB_W);
    localparam int IDX_W    = ADDR_W - ADDR_LSB;
    localparam int RAM_AW   = (clog2(DEPTH) > 0) ? clog2(DEPTH) : 1;
    localparam int CNT_W    = (WAIT_CYCLES > 0) ? clog2(WAIT_CYCLES + 1) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'((WAIT_CYCLES > 0) ? WAIT_CYCLES - 1 : 0);

    state_t             state_reg, state_next;
    logic [CNT_W-1:0]   cnt_reg, cnt_next;
    logic               write_reg;
    logic [ADDR_W-1:0]  addr_reg;
    logic [DATA_W-1:0]  wdata_reg;
    logic [STRB_W-1:0]  strb_reg;
    logic               pready_reg, pslverr_reg, rd_vld_reg;

    logic               accept, enter_resp;
    logic               cur_write;
    logic [ADDR_W-1:0]  cur_addr;
    logic [DATA_W-1:0]  cur_wdata;
    logic [STRB_W-1:0]  cur_strb;
    logic [IDX_W-1:0]   idx;
    logic               unaligned, out_of_range, err;
    logic [STRB_W-1:0]  ram_we;
    logic               ram_re;
    logic [DATA_W-1:0]  ram_rdata;

    assign accept = (state_reg == IDLE) && psel && penable;

    // With no wait states the RAM is hit on the accepting edge, so the live bus
    // feeds the datapath in IDLE; afterwards only the latched copy is used.
    assign cur_write = (state_reg == IDLE) ? pwrite : write_reg;
    assign cur_addr  = (state_reg == IDLE) ? paddr  : addr_reg;
    assign cur_wdata = (state_reg == IDLE) ? pwdata : wdata_reg;
    assign cur_strb  = (state_reg == IDLE) ? pstrb  : strb_reg;

    assign idx          = cur_addr[ADDR_W-1:ADDR_LSB];
    assign out_of_range = 32'(idx) >= 32'(DEPTH);

    generate
        if (ADDR_LSB > 0) begin : g_align
            assign unaligned = |cur_addr[ADDR_LSB-1:0];
        end else begin : g_noalign
            assign unaligned = 1'b0;
        end
    endgenerate

    assign err = unaligned || out_of_range;

    always_comb begin
        state_next = state_reg;
        cnt_next   = cnt_reg;
        case (state_reg)
            IDLE: begin
                if (accept) begin
                    cnt_next   = '0;
                    state_next = (WAIT_CYCLES == 0) ? RESP : WAIT;
                end
            end
            WAIT: begin
                if (!psel) begin
                    state_next = IDLE;
                    cnt_next   = '0;
                end else if (cnt_reg == CNT_LAST) begin
                    state_next = RESP;
                    cnt_next   = '0;
                end else begin
                    cnt_next = cnt_reg + 1'b1;
                end
            end
            RESP:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    assign enter_resp = (state_next == RESP) && (state_reg != RESP);
    assign ram_we     = (enter_resp && cur_write && !err) ? cur_strb : '0;
    assign ram_re     = enter_resp && !cur_write && !err;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_reg   <= IDLE;
            cnt_reg     <= '0;
            write_reg   <= 1'b0;
            addr_reg    <= '0;
            wdata_reg   <= '0;
            strb_reg    <= '0;
            pready_reg  <= 1'b0;
            pslverr_reg <= 1'b0;
            rd_vld_reg  <= 1'b0;
        end else begin
            state_reg   <= state_next;
            cnt_reg     <= cnt_next;
            pready_reg  <= enter_resp;
            pslverr_reg <= enter_resp && err;
            if (accept) begin
                write_reg <= pwrite;
                addr_reg  <= paddr;
                wdata_reg <= pwdata;
                strb_reg  <= pstrb;
            end
            // The RAM output register holds the last good read; errored reads mask it to zero.
            if (enter_resp && !cur_write) begin
                rd_vld_reg <= !err;
            end
        end
    end

    apb_bytewe_ram #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH)
    ) u_ram (
        .clk    (clk),
        .we     (ram_we),
        .re     (ram_re),
        .addr   (idx[RAM_AW-1:0]),
        .wdata  (cur_wdata),
        .rdata  (ram_rdata)
    );

    assign prdata  = rd_vld_reg ? ram_rdata : '0;
    assign pready  = pready_reg;
    assign pslverr = pslverr_reg;

endmodule

// File: tb/tb_apb_mem_slave_p.sv
// Directed bench for apb_mem_slave_p: one instance without wait states, one with three.
module tb_apb_mem_slave_p;

    logic        clk = 1'b0;
    logic        resetn = 1'b0;
    logic        psel0 = 1'b0, psel1 = 1'b0, penable = 1'b0, pwrite = 1'b0;
    logic [11:0] paddr = '0;
    logic [31:0] pwdata = '0;
    logic [3:0]  pstrb = '0;
    logic [31:0] prdata0, prdata1;
    logic        pready0, pready1, pslverr0, pslverr1;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    apb_mem_slave_p #(.DATA_W(32), .ADDR_W(12), .DEPTH(256), .WAIT_CYCLES(0)) u_dut0 (
        .clk(clk), .resetn(resetn), .psel(psel0), .penable(penable), .pwrite(pwrite),
        .paddr(paddr), .pwdata(pwdata), .pstrb(pstrb),
        .prdata(prdata0), .pready(pready0), .pslverr(pslverr0)
    );

    apb_mem_slave_p #(.DATA_W(32), .ADDR_W(12), .DEPTH(256), .WAIT_CYCLES(3)) u_dut1 (
        .clk(clk), .resetn(resetn), .psel(psel1), .penable(penable), .pwrite(pwrite),
        .paddr(paddr), .pwdata(pwdata), .pstrb(pstrb),
        .prdata(prdata1), .pready(pready1), .pslverr(pslverr1)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    function automatic logic rdy(input int inst);
        return (inst == 0) ? pready0 : pready1;
    endfunction

    // One full SETUP+ACCESS transfer. Bus inputs are scrambled once ACCESS has
    // been accepted to show the slave works from its latched request.
    task automatic xfer(input int inst, input bit wr, input logic [11:0] a,
                        input logic [31:0] d, input logic [3:0] s,
                        output logic [31:0] rd, output logic err, output int cyc);
        @(posedge clk); #1;
        psel0 = (inst == 0); psel1 = (inst == 1);
        penable = 1'b0; pwrite = wr; paddr = a; pwdata = d; pstrb = s;
        @(posedge clk); #1;
        penable = 1'b1;
        cyc = 1;
        while (!rdy(inst) && cyc < 40) begin
            @(posedge clk); #1;
            cyc++;
            pwdata = ~d;
            paddr  = a ^ 12'h004;
        end
        check("pready_hi", {63'd0, rdy(inst)}, 64'd1);
        rd  = (inst == 0) ? prdata0 : prdata1;
        err = (inst == 0) ? pslverr0 : pslverr1;
        @(posedge clk); #1;
        psel0 = 1'b0; psel1 = 1'b0; penable = 1'b0;
        check("pready_lo", {63'd0, rdy(inst)}, 64'd0);
        $display("xfer inst=%0d wr=%0d addr=%h wdata=%h strb=%h rdata=%h err=%0d cycles=%0d",
                 inst, wr, a, d, s, rd, err, cyc);
    endtask

    logic [31:0] rd;
    logic        err;
    int          cyc;

    initial begin
        repeat (3) @(posedge clk);
        #1;
        check("rst_pready0",  {63'd0, pready0},  64'd0);
        check("rst_pslverr0", {63'd0, pslverr0}, 64'd0);
        check("rst_prdata0",  {32'd0, prdata0},  64'd0);
        check("rst_pready1",  {63'd0, pready1},  64'd0);
        resetn = 1'b1;

        // Basic write/read, no wait states
        xfer(0, 1, 12'h010, 32'hDEADBEEF, 4'hF, rd, err, cyc);
        check("wr_err", {63'd0, err}, 64'd0);
        check("wr_cyc", 64'(cyc), 64'd2);
        xfer(0, 0, 12'h010, 32'h0, 4'h0, rd, err, cyc);
        check("rd_data", {32'd0, rd}, {32'd0, 32'hDEADBEEF});
        check("rd_err",  {63'd0, err}, 64'd0);
        check("rd_cyc",  64'(cyc), 64'd2);

        // Byte strobes
        xfer(0, 1, 12'h010, 32'h11223344, 4'b0101, rd, err, cyc);
        xfer(0, 0, 12'h010, 32'h0, 4'h0, rd, err, cyc);
        check("strb_data", {32'd0, rd}, {32'd0, 32'hDE22BE44});

        // Empty strobe is a legal no-op
        xfer(0, 1, 12'h010, 32'hFFFFFFFF, 4'h0, rd, err, cyc);
        check("strb0_err", {63'd0, err}, 64'd0);
        xfer(0, 0, 12'h010, 32'h0, 4'h0, rd, err, cyc);
        check("strb0_data", {32'd0, rd}, {32'd0, 32'hDE22BE44});

        // Range error: word 256 does not exist and must not alias word 0
        xfer(0, 1, 12'h000, 32'hCAFEF00D, 4'hF, rd, err, cyc);
        xfer(0, 1, 12'h400, 32'h55555555, 4'hF, rd, err, cyc);
        check("range_wr_err", {63'd0, err}, 64'd1);
        xfer(0, 0, 12'h400, 32'h0, 4'h0, rd, err, cyc);
        check("range_rd_err",  {63'd0, err}, 64'd1);
        check("range_rd_data", {32'd0, rd}, 64'd0);
        xfer(0, 0, 12'h000, 32'h0, 4'h0, rd, err, cyc);
        check("word0_data", {32'd0, rd}, {32'd0, 32'hCAFEF00D});

        // Alignment error then recovery
        xfer(0, 0, 12'h012, 32'h0, 4'h0, rd, err, cyc);
        check("unal_err",  {63'd0, err}, 64'd1);
        check("unal_data", {32'd0, rd}, 64'd0);
        xfer(0, 0, 12'h010, 32'h0, 4'h0, rd, err, cyc);
        check("al_err",  {63'd0, err}, 64'd0);
        check("al_data", {32'd0, rd}, {32'd0, 32'hDE22BE44});

        // Asynchronous reset while a read response is on the bus
        @(posedge clk); #1;
        psel0 = 1'b1; penable = 1'b0; pwrite = 1'b0; paddr = 12'h010;
        @(posedge clk); #1;
        penable = 1'b1;
        @(posedge clk); #1;
        check("pre_rst_rdy",  {63'd0, pready0}, 64'd1);
        check("pre_rst_data", {32'd0, prdata0}, {32'd0, 32'hDE22BE44});
        resetn = 1'b0;
        #1;
        check("arst_pready",  {63'd0, pready0},  64'd0);
        check("arst_pslverr", {63'd0, pslverr0}, 64'd0);
        check("arst_prdata",  {32'd0, prdata0},  64'd0);
        $display("xfer inst=0 async reset during read response");
        psel0 = 1'b0; penable = 1'b0;
        @(posedge clk); #1;
        resetn = 1'b1;

        // Three wait states
        xfer(1, 1, 12'h020, 32'hA5A5A5A5, 4'hF, rd, err, cyc);
        check("w3_wr_cyc", 64'(cyc), 64'd5);
        check("w3_wr_err", {63'd0, err}, 64'd0);
        xfer(1, 0, 12'h020, 32'h0, 4'h0, rd, err, cyc);
        check("w3_rd_cyc",  64'(cyc), 64'd5);
        check("w3_rd_data", {32'd0, rd}, {32'd0, 32'hA5A5A5A5});

        // Reset in the second ACCESS cycle discards the pending write
        @(posedge clk); #1;
        psel1 = 1'b1; penable = 1'b0; pwrite = 1'b1; paddr = 12'h020;
        pwdata = 32'h12345678; pstrb = 4'hF;
        @(posedge clk); #1;
        penable = 1'b1;
        @(posedge clk); #1;
        check("w3_mid_rdy", {63'd0, pready1}, 64'd0);
        resetn = 1'b0;
        $display("xfer inst=1 write 0x020 aborted by reset");
        @(posedge clk); #1;
        psel1 = 1'b0; penable = 1'b0;
        @(posedge clk); #1;
        resetn = 1'b1;
        xfer(1, 0, 12'h020, 32'h0, 4'h0, rd, err, cyc);
        check("w3_keep_data", {32'd0, rd}, {32'd0, 32'hA5A5A5A5});

        xfer(1, 0, 12'h021, 32'h0, 4'h0, rd, err, cyc);
        check("w3_unal_err",  {63'd0, err}, 64'd1);
        check("w3_unal_data", {32'd0, rd}, 64'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
